// File: rtl/regfile_arbiter_pkg.sv
// Shared constants, requester ids and the issue-stage record for the
// two-requester regfile_sipo arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 32;
  localparam int REG_SIZE = 128;

  // Requester ids; also the bit index of each side in the arbiter vectors.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // One granted request as it sits on the regfile ports.
  typedef struct packed {
    logic              valid;
    logic              write;
    logic              id;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } iss_t;

  // A 3-wide read starting at addr must stay inside the register file.
  function automatic logic rd_out_of_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) > (REG_SIZE - 3);
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Request/response handshake of one client engine towards the arbiter.
// master = client side, slave = arbiter side.
interface regfile_arbiter_if;

  logic                           valid;
  logic                           ready;
  logic                           write;
  logic [regfile_pkg::ADDR_W-1:0] addr;
  logic [regfile_pkg::DATA_W-1:0] wdata;
  logic                           lock;
  logic                           rsp_valid;
  logic                           rsp_err;

  modport master (
    output valid, write, addr, wdata, lock,
    input  ready, rsp_valid, rsp_err
  );

  modport slave (
    input  valid, write, addr, wdata, lock,
    output ready, rsp_valid, rsp_err
  );

endinterface

// File: rtl/regfile_arbiter_rr_lock_arb2.sv
// Two-way round-robin arbiter with a bounded burst lock.
// A side that is granted with lock=1 becomes owner and keeps the grant while it
// stays valid and locked, for at most LOCK_MAX consecutive accepts.
module rr_lock_arb2 import regfile_pkg::*; #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic [1:0] lock_i,
  output logic [1:0] ready_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             rr_q, rr_d;           // side that wins the next tie
  logic             own_vld_q, own_vld_d;
  logic             own_q, own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;         // owner's consecutive accepts
  logic             held;
  logic             gnt;
  logic             acc;

  // Pick the winner: held lock first, then single requester, then rr on a tie.
  always_comb begin
    held    = own_vld_q && valid_i[own_q] && lock_i[own_q] &&
              (cnt_q < CNT_W'(LOCK_MAX));
    gnt     = REQ_A;
    if (held)
      gnt = own_q;
    else if (valid_i[REQ_A] && valid_i[REQ_B])
      gnt = rr_q;
    else if (valid_i[REQ_B])
      gnt = REQ_B;
    acc     = |valid_i;
    ready_o = '0;
    ready_o[gnt] = acc;
  end

  // Pointer and lock bookkeeping. A grant outside a held lock starts a new
  // burst, so an expired owner that wins again counts from 1.
  always_comb begin
    rr_d      = rr_q;
    own_vld_d = own_vld_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    if (acc) begin
      rr_d = ~gnt;
      if (lock_i[gnt]) begin
        own_vld_d = 1'b1;
        own_d     = gnt;
        cnt_d     = held ? cnt_q + CNT_W'(1) : CNT_W'(1);
      end else begin
        own_vld_d = 1'b0;
        cnt_d     = '0;
      end
    end else begin
      // No accept means the owner dropped valid: lock is released.
      own_vld_d = 1'b0;
      cnt_d     = '0;
    end
  end

  // State registers; reset favours A with no owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= REQ_A;
      own_vld_q <= 1'b0;
      own_q     <= REQ_A;
      cnt_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one regfile_sipo port set between requesters A and B.
// Accept at E0 -> regfile ports driven E0..E1 -> read response E1..E2.
module regfile_arbiter import regfile_pkg::*; #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  a_if,
  regfile_arbiter_if.slave  b_if,
  output logic [DATA_W-1:0] rsp_src1,
  output logic [DATA_W-1:0] rsp_src2,
  output logic [DATA_W-1:0] rsp_src3,
  output logic              rf_enable,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_src_addr,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_src1,
  input  logic [DATA_W-1:0] rf_src2,
  input  logic [DATA_W-1:0] rf_src3
);

  logic [1:0] req_vld;
  logic [1:0] req_lock;
  logic [1:0] gnt;

  // Nothing is accepted while reset is held, so no request gets lost.
  assign req_vld  = {b_if.valid, a_if.valid} & {2{~rst}};
  assign req_lock = {b_if.lock, a_if.lock};

  rr_lock_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (req_vld),
    .lock_i  (req_lock),
    .ready_o (gnt)
  );

  assign a_if.ready = gnt[REQ_A];
  assign b_if.ready = gnt[REQ_B];

  iss_t iss_q, iss_d;
  logic rsp_vld_q, rsp_id_q, rsp_err_q;

  // Mux the granted request into an issue record; idle slots are all-zero.
  always_comb begin
    iss_d = '0;
    if (gnt[REQ_B]) begin
      iss_d.valid = 1'b1;
      iss_d.id    = REQ_B;
      iss_d.write = b_if.write;
      iss_d.addr  = b_if.addr;
      iss_d.data  = b_if.write ? b_if.wdata : '0;
    end else if (gnt[REQ_A]) begin
      iss_d.valid = 1'b1;
      iss_d.id    = REQ_A;
      iss_d.write = a_if.write;
      iss_d.addr  = a_if.addr;
      iss_d.data  = a_if.write ? a_if.wdata : '0;
    end
    iss_d.err = iss_d.valid & ~iss_d.write & rd_out_of_range(iss_d.addr);
  end

  // Issue stage: holds the request presented to the regfile this cycle.
  always_ff @(posedge clk) begin
    if (rst) iss_q <= '0;
    else     iss_q <= iss_d;
  end

  // Rejected reads still occupy a slot but never touch the regfile.
  assign rf_enable     = iss_q.valid & ~iss_q.err;
  assign rf_write      = iss_q.valid & iss_q.write;
  assign rf_src_addr   = iss_q.addr;
  assign rf_write_addr = iss_q.addr;
  assign rf_write_data = iss_q.data;

  // Response tag stage: lines up with the regfile's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= REQ_A;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_vld_q <= iss_q.valid & ~iss_q.write;
      rsp_id_q  <= iss_q.id;
      rsp_err_q <= iss_q.err;
    end
  end

  assign a_if.rsp_valid = rsp_vld_q & (rsp_id_q == REQ_A);
  assign b_if.rsp_valid = rsp_vld_q & (rsp_id_q == REQ_B);
  assign a_if.rsp_err   = a_if.rsp_valid & rsp_err_q;
  assign b_if.rsp_err   = b_if.rsp_valid & rsp_err_q;

  assign rsp_src1 = rsp_err_q ? '0 : rf_src1;
  assign rsp_src2 = rsp_err_q ? '0 : rf_src2;
  assign rsp_src3 = rsp_err_q ? '0 : rf_src3;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural regfile_sipo behind it.
`timescale 1ns/1ps
module tb_regfile_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  regfile_arbiter_if a_if();
  regfile_arbiter_if b_if();

  logic [DATA_W-1:0] rsp_src1, rsp_src2, rsp_src3;
  logic              rf_enable, rf_write;
  logic [ADDR_W-1:0] rf_src_addr, rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_src1, rf_src2, rf_src3;

  regfile_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst), .a_if(a_if), .b_if(b_if),
    .rsp_src1(rsp_src1), .rsp_src2(rsp_src2), .rsp_src3(rsp_src3),
    .rf_enable(rf_enable), .rf_write(rf_write),
    .rf_src_addr(rf_src_addr), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_src3(rf_src3)
  );

  // regfile_sipo stand-in: synchronous write, registered 3-wide read.
  // Untouched entries hold 0x1000_0000 | index.
  logic [DATA_W-1:0] mem [REG_SIZE];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < REG_SIZE; i++) mem[i] <= 32'h1000_0000 | 32'(i);
    end else if (rf_enable) begin
      if (rf_write) mem[rf_write_addr] <= rf_write_data;
      else begin
        rf_src1 <= mem[int'(rf_src_addr)];
        rf_src2 <= mem[int'(rf_src_addr) + 1];
        rf_src3 <= mem[int'(rf_src_addr) + 2];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic w, input logic lk,
                       input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    a_if.valid = v; a_if.write = w; a_if.lock = lk; a_if.addr = ad; a_if.wdata = d;
  endtask

  task automatic drv_b(input logic v, input logic w, input logic lk,
                       input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    b_if.valid = v; b_if.write = w; b_if.lock = lk; b_if.addr = ad; b_if.wdata = d;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; nxt(); nxt(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] exp3;
  logic [6:0] exp4;

  initial begin
    // ---- 1: reset state
    rst = 1'b1; mem_init = 1'b1;
    drv_a(1'b0, 1'b0, 1'b0, '0, '0);
    drv_b(1'b0, 1'b0, 1'b0, '0, '0);
    nxt(); mem_init = 1'b0; nxt();
    mid();
    chk1 ("rst rf_enable", rf_enable, 1'b0);
    chk1 ("rst rf_write", rf_write, 1'b0);
    chk32("rst rf_src_addr", 32'(rf_src_addr), 32'd0);
    chk32("rst rf_write_addr", 32'(rf_write_addr), 32'd0);
    chk32("rst rf_write_data", rf_write_data, 32'd0);
    chk1 ("rst a_ready", a_if.ready, 1'b0);
    chk1 ("rst b_ready", b_if.ready, 1'b0);
    chk1 ("rst a_rsp_valid", a_if.rsp_valid, 1'b0);
    chk1 ("rst b_rsp_valid", b_if.rsp_valid, 1'b0);
    nxt(); rst = 1'b0;

    // ---- 2: A writes REG[0..4], then reads 0
    for (int i = 0; i < 5; i++) begin
      drv_a(1'b1, 1'b1, 1'b0, 7'(i), 32'hffff_0000 | 32'(i));
      mid(); chk1("t2 a_ready write", a_if.ready, 1'b1);
      nxt();
    end
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, '0);
    mid();
    chk1 ("t2 a_ready read", a_if.ready, 1'b1);
    chk1 ("t2 rf_write", rf_write, 1'b1);
    chk32("t2 rf_write_addr", 32'(rf_write_addr), 32'd4);
    chk32("t2 rf_write_data", rf_write_data, 32'hffff_0004);
    nxt();
    drv_a(1'b0, 1'b0, 1'b0, '0, '0);
    mid();
    chk1 ("t2 rf_enable rd", rf_enable, 1'b1);
    chk1 ("t2 rf_write rd", rf_write, 1'b0);
    chk32("t2 rf_src_addr", 32'(rf_src_addr), 32'd0);
    chk1 ("t2 a_rsp early", a_if.rsp_valid, 1'b0);
    nxt();
    mid();
    chk1 ("t2 a_rsp_valid", a_if.rsp_valid, 1'b1);
    chk1 ("t2 b_rsp_valid", b_if.rsp_valid, 1'b0);
    chk1 ("t2 a_rsp_err", a_if.rsp_err, 1'b0);
    chk32("t2 src1", rsp_src1, 32'hffff_0000);
    chk32("t2 src2", rsp_src2, 32'hffff_0001);
    chk32("t2 src3", rsp_src3, 32'hffff_0002);
    nxt();
    mid(); chk1("t2 a_rsp single", a_if.rsp_valid, 1'b0);
    chk1("t2 idle rf_enable", rf_enable, 1'b0);

    // ---- RAW: write 10 then read 10 on the next cycle
    drv_a(1'b1, 1'b1, 1'b0, 7'd10, 32'hdead_beef); nxt();
    drv_a(1'b1, 1'b0, 1'b0, 7'd10, '0); nxt();
    drv_a(1'b0, 1'b0, 1'b0, '0, '0); nxt();
    mid();
    chk1 ("raw a_rsp_valid", a_if.rsp_valid, 1'b1);
    chk32("raw src1", rsp_src1, 32'hdead_beef);
    chk32("raw src2", rsp_src2, 32'h1000_000b);
    nxt();

    // ---- 3: both read, no lock -> alternate A,B,A,B,A,B
    do_reset();
    exp3 = 6'b010101;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drv_a(1'b1, 1'b0, 1'b0, 7'd0, '0);
        drv_b(1'b1, 1'b0, 1'b0, 7'd120, '0);
      end else begin
        drv_a(1'b0, 1'b0, 1'b0, '0, '0);
        drv_b(1'b0, 1'b0, 1'b0, '0, '0);
      end
      mid();
      if (k < 6) begin
        chk1("t3 a_ready", a_if.ready, exp3[k]);
        chk1("t3 b_ready", b_if.ready, ~exp3[k]);
      end
      chk1("t3 ready excl", a_if.ready & b_if.ready, 1'b0);
      if (k >= 2) begin
        chk1 ("t3 a_rsp", a_if.rsp_valid, exp3[k-2]);
        chk1 ("t3 b_rsp", b_if.rsp_valid, ~exp3[k-2]);
        chk32("t3 src1", rsp_src1, exp3[k-2] ? 32'hffff_0000 : 32'h1000_0078);
      end
      nxt();
    end

    // ---- 4: A locked burst, LOCK_MAX=4 -> AAAA B AA
    do_reset();
    exp4 = 7'b110_1111;
    for (int k = 0; k < 7; k++) begin
      drv_a(1'b1, 1'b0, 1'b1, 7'd1, '0);
      drv_b(1'b1, 1'b0, 1'b0, 7'd120, '0);
      mid();
      chk1("t4 a_ready", a_if.ready, exp4[k]);
      chk1("t4 b_ready", b_if.ready, ~exp4[k]);
      if (k == 5) begin
        chk1 ("t4 a_rsp", a_if.rsp_valid, 1'b1);
        chk32("t4 a src1", rsp_src1, 32'hffff_0001);
      end
      if (k == 6) begin
        chk1 ("t4 b_rsp", b_if.rsp_valid, 1'b1);
        chk32("t4 b src1", rsp_src1, 32'h1000_0078);
      end
      nxt();
    end
    drv_a(1'b0, 1'b0, 1'b0, '0, '0);
    drv_b(1'b0, 1'b0, 1'b0, '0, '0);
    nxt(); nxt(); nxt();

    // ---- 5: B reads 126 (out of range) then 125 (last legal base)
    drv_b(1'b1, 1'b0, 1'b0, 7'd126, '0);
    mid(); chk1("t5 b_ready 126", b_if.ready, 1'b1);
    nxt();
    drv_b(1'b1, 1'b0, 1'b0, 7'd125, '0);
    mid();
    chk1("t5 b_ready 125", b_if.ready, 1'b1);
    chk1("t5 rf_enable err slot", rf_enable, 1'b0);
    nxt();
    drv_b(1'b0, 1'b0, 1'b0, '0, '0);
    mid();
    chk1 ("t5 rf_enable 125", rf_enable, 1'b1);
    chk32("t5 rf_src_addr", 32'(rf_src_addr), 32'd125);
    chk1 ("t5 b_rsp err", b_if.rsp_valid, 1'b1);
    chk1 ("t5 b_rsp_err", b_if.rsp_err, 1'b1);
    chk1 ("t5 a_rsp", a_if.rsp_valid, 1'b0);
    chk32("t5 err src1", rsp_src1, 32'd0);
    chk32("t5 err src2", rsp_src2, 32'd0);
    chk32("t5 err src3", rsp_src3, 32'd0);
    nxt();
    mid();
    chk1 ("t5 b_rsp 125", b_if.rsp_valid, 1'b1);
    chk1 ("t5 b_rsp_err 125", b_if.rsp_err, 1'b0);
    chk32("t5 src1 125", rsp_src1, 32'h1000_007d);
    chk32("t5 src3 125", rsp_src3, 32'h1000_007f);
    nxt();

    // ---- 6: reset right after a read accept drops the response
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, '0);
    mid(); chk1("t6 a_ready", a_if.ready, 1'b1);
    nxt();
    drv_a(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    mid(); chk1("t6 issued before rst", rf_enable, 1'b1);
    nxt();
    rst = 1'b0;
    mid();
    chk1("t6 no rsp after rst", a_if.rsp_valid, 1'b0);
    chk1("t6 rf_enable cleared", rf_enable, 1'b0);
    nxt();
    mid(); chk1("t6 still no rsp", a_if.rsp_valid, 1'b0);
    nxt();
    drv_a(1'b1, 1'b0, 1'b0, 7'd0, '0); nxt();
    drv_a(1'b0, 1'b0, 1'b0, '0, '0); nxt();
    mid();
    chk1 ("t6 a_rsp after rst", a_if.rsp_valid, 1'b1);
    chk32("t6 src1", rsp_src1, 32'hffff_0000);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
